// File: rtl/newmot_pkg.sv
// Shared register map and bit positions for the step/direction decoder.
// Included by the decoder RTL and by anything that talks to it over Wishbone.
package newmot_pkg;

   localparam int ADR_W = 13;
   localparam int DAT_W = 32;

   typedef enum logic [ADR_W-1:0] {
      REG_CTRL     = 13'd0,
      REG_POSITION = 13'd1,
      REG_STATUS   = 13'd2,
      REG_COMPARE  = 13'd3,
      REG_PERIOD   = 13'd4
   } reg_offset_e;

   localparam int CTRL_ENABLE     = 0;
   localparam int CTRL_DIR_INVERT = 1;
   localparam int CTRL_IRQ_EN     = 2;

   localparam int STATUS_CMP_HIT = 0;
   localparam int STATUS_OVF     = 1;
   localparam int STATUS_DIR_ERR = 2;

   // True when a +/-1 step from pos crosses the signed 32-bit boundary.
   function automatic logic signed_wrap(input logic [DAT_W-1:0] pos, input logic up);
      return up ? (pos == 32'h7FFF_FFFF) : (pos == 32'h8000_0000);
   endfunction

endpackage

// File: rtl/step_dir_decoder_input_filter.sv
// Two-flop synchronizer followed by a run-length filter: the output only
// follows the synchronized input after FILTER_LEN identical samples.
module input_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [1:0] sync_reg;
   logic [3:0] cnt_reg;
   logic       filt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= '0;
         cnt_reg  <= '0;
         filt_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], din};
         // cnt_reg counts differing samples already seen; any agreeing sample restarts the run
         if (sync_reg[1] == filt_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == 4'(FILTER_LEN - 1)) begin
            filt_reg <= sync_reg[1];
            cnt_reg  <= '0;
         end else begin
            cnt_reg <= cnt_reg + 4'd1;
         end
      end
   end

   assign dout = filt_reg;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/direction quadrature-style position counter with a Wishbone classic
// register interface, overflow/compare/direction-setup status and interrupt.
module step_dir_decoder
   import newmot_pkg::*;
#(
   parameter int FILTER_LEN = 4,
   parameter int DIR_SETUP  = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [3:0]  wb_sel,
   input  logic [12:0] wb_adr,
   input  logic [31:0] wb_dat_w,
   output logic [31:0] wb_dat_r,
   output logic        wb_ack,
   input  logic        step_in,
   input  logic        dir_in,
   output logic        irq
);

   logic        step_filt;
   logic        dir_filt;
   logic        step_prev_reg;
   logic        dir_prev_reg;
   logic [3:0]  dir_age_reg;
   logic [2:0]  ctrl_reg;
   logic [2:0]  status_reg;
   logic [31:0] position_reg;
   logic [31:0] compare_reg;
   logic [31:0] period_reg;
   logic [31:0] period_cnt_reg;

   logic        wb_req;
   logic        wr_en;
   logic        pos_wr;
   logic        count_event;
   logic        count_ok;
   logic        up;
   logic        dir_recent;
   logic [31:0] pos_next;
   logic [2:0]  status_set;
   logic [2:0]  status_clr;
   logic [31:0] rd_data;
   logic        unused_ok;

   input_filter #(.FILTER_LEN(FILTER_LEN)) u_step_filter (
      .clk  (sys_clk),
      .rst  (sys_rst),
      .din  (step_in),
      .dout (step_filt)
   );

   input_filter #(.FILTER_LEN(FILTER_LEN)) u_dir_filter (
      .clk  (sys_clk),
      .rst  (sys_rst),
      .din  (dir_in),
      .dout (dir_filt)
   );

   assign unused_ok = &{1'b0, wb_sel};

   // The ack register itself masks the second cycle of a held strobe.
   assign wb_req = wb_cyc & wb_stb & ~wb_ack;
   assign wr_en  = wb_req & wb_we;
   assign pos_wr = wr_en && (wb_adr == REG_POSITION);

   assign count_event = ctrl_reg[CTRL_ENABLE] & step_filt & ~step_prev_reg;
   assign count_ok    = count_event & ~pos_wr;
   assign up          = dir_filt ^ ctrl_reg[CTRL_DIR_INVERT];
   assign pos_next    = up ? position_reg + 32'd1 : position_reg - 32'd1;
   assign dir_recent  = (dir_filt != dir_prev_reg) || (dir_age_reg < 4'(DIR_SETUP));

   always_comb begin
      status_set = '0;
      status_set[STATUS_CMP_HIT] = count_ok & (pos_next == compare_reg);
      status_set[STATUS_OVF]     = count_ok & signed_wrap(position_reg, up);
      status_set[STATUS_DIR_ERR] = count_ok & dir_recent;
      status_clr = '0;
      if (wr_en && (wb_adr == REG_STATUS)) begin
         status_clr = wb_dat_w[2:0];
      end
   end

   always_comb begin
      rd_data = '0;
      case (wb_adr)
         REG_CTRL:     rd_data = {29'd0, ctrl_reg};
         REG_POSITION: rd_data = position_reg;
         REG_STATUS:   rd_data = {29'd0, status_reg};
         REG_COMPARE:  rd_data = compare_reg;
         REG_PERIOD:   rd_data = period_reg;
         default:      rd_data = '0;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         step_prev_reg  <= 1'b0;
         dir_prev_reg   <= 1'b0;
         dir_age_reg    <= '0;
         ctrl_reg       <= '0;
         status_reg     <= '0;
         position_reg   <= '0;
         compare_reg    <= '0;
         period_reg     <= '0;
         period_cnt_reg <= '0;
         wb_ack         <= 1'b0;
         wb_dat_r       <= '0;
         irq            <= 1'b0;
      end else begin
         // Edge history freezes while disabled, so a step already high counts once on enable.
         if (ctrl_reg[CTRL_ENABLE]) begin
            step_prev_reg <= step_filt;
         end
         dir_prev_reg <= dir_filt;
         if (dir_filt != dir_prev_reg) begin
            dir_age_reg <= 4'd1;
         end else if (dir_age_reg != 4'hF) begin
            dir_age_reg <= dir_age_reg + 4'd1;
         end

         if (wr_en) begin
            case (wb_adr)
               REG_CTRL:    ctrl_reg    <= wb_dat_w[2:0];
               REG_COMPARE: compare_reg <= wb_dat_w;
               default:     ;
            endcase
         end

         if (pos_wr) begin
            position_reg <= wb_dat_w;
         end else if (count_ok) begin
            position_reg <= pos_next;
         end

         if (count_ok) begin
            period_reg     <= period_cnt_reg;
            period_cnt_reg <= 32'd1;
         end else if (period_cnt_reg != 32'hFFFF_FFFF) begin
            period_cnt_reg <= period_cnt_reg + 32'd1;
         end

         status_reg <= (status_reg & ~status_clr) | status_set;
         irq        <= ctrl_reg[CTRL_IRQ_EN] & (status_reg[STATUS_CMP_HIT] | status_reg[STATUS_OVF]);
         wb_ack     <= wb_req;
         wb_dat_r   <= (wb_req & ~wb_we) ? rd_data : 32'd0;
      end
   end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed and randomized bench for step_dir_decoder; positions are predicted
// from the step/direction rules with plain arithmetic.
module tb_step_dir_decoder;
   import newmot_pkg::*;

   localparam int FL = 4;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [3:0]  wb_sel = 4'hF;
   logic [12:0] wb_adr = '0;
   logic [31:0] wb_dat_w = '0;
   logic [31:0] wb_dat_r;
   logic        wb_ack;
   logic        step_in = 1'b0, dir_in = 1'b0;
   logic        irq;

   int tests = 0;
   int fails = 0;

   always #5 sys_clk = ~sys_clk;

   step_dir_decoder #(.FILTER_LEN(FL), .DIR_SETUP(2)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .wb_cyc   (wb_cyc),
      .wb_stb   (wb_stb),
      .wb_we    (wb_we),
      .wb_sel   (wb_sel),
      .wb_adr   (wb_adr),
      .wb_dat_w (wb_dat_w),
      .wb_dat_r (wb_dat_r),
      .wb_ack   (wb_ack),
      .step_in  (step_in),
      .dir_in   (dir_in),
      .irq      (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [12:0] adr, input logic [31:0] wdat,
                          output logic [31:0] rdat);
      logic got;
      got = 1'b0;
      rdat = '0;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = wdat;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge sys_clk);
         #1;
         if (wb_ack === 1'b1) begin
            got  = 1'b1;
            rdat = wb_dat_r;
         end
      end
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      check("wb_ack", 32'(got), 32'd1);
   endtask

   task automatic wb_wr(input logic [12:0] adr, input logic [31:0] wdat);
      logic [31:0] dummy;
      wb_xfer(1'b1, adr, wdat, dummy);
   endtask

   task automatic wb_rd(input logic [12:0] adr, output logic [31:0] rdat);
      wb_xfer(1'b0, adr, 32'd0, rdat);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, pos_m, st_m;
      logic        dir, inv, up;
      bit          glitch;
      int          w;

      // Reset state
      tick(3);
      check("rst_ack", 32'(wb_ack), 32'd0);
      check("rst_dat_r", wb_dat_r, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      sys_rst = 1'b0;
      tick(2);
      for (int a = 0; a < 5; a++) begin
         wb_rd(13'(a), rd);
         check("rst_reg", rd, 32'd0);
      end

      // Step held high while disabled counts exactly once when enabled
      dir_in = 1'b1; step_in = 1'b1;
      tick(20);
      wb_rd(REG_POSITION, rd);
      check("disabled_hold", rd, 32'd0);
      wb_wr(REG_CTRL, 32'd1);
      tick(20);
      wb_rd(REG_POSITION, rd);
      check("held_step_once", rd, 32'd1);
      step_in = 1'b0;
      tick(10);

      // Ten clean pulses with latency probes on either side of the update edge
      wb_wr(REG_POSITION, 32'd0);
      pos_m = 32'd0;
      for (int i = 0; i < 10; i++) begin
         step_in = 1'b1;
         if (i % 2 == 0) begin
            tick(FL + 2);
            wb_rd(REG_POSITION, rd);
            check("lat_before", rd, pos_m);
         end else begin
            tick(FL + 3);
            wb_rd(REG_POSITION, rd);
            check("lat_after", rd, pos_m + 32'd1);
         end
         step_in = 1'b0;
         pos_m = pos_m + 32'd1;
         tick(12);
      end
      wb_rd(REG_POSITION, rd);
      check("ten_steps", rd, 32'd10);

      // Short glitches are rejected, a longer pulse counts
      step_in = 1'b1; tick(2); step_in = 1'b0; tick(12);
      step_in = 1'b1; tick(2); step_in = 1'b0; tick(12);
      wb_rd(REG_POSITION, rd);
      check("glitch", rd, 32'd10);
      step_in = 1'b1; tick(6); step_in = 1'b0; tick(12);
      wb_rd(REG_POSITION, rd);
      check("pulse6", rd, 32'd11);

      // Signed overflow
      wb_wr(REG_POSITION, 32'h7FFF_FFFF);
      wb_wr(REG_CTRL, 32'd5);
      step_in = 1'b1; tick(8); step_in = 1'b0; tick(12);
      wb_rd(REG_POSITION, rd);
      check("ovf_pos", rd, 32'h8000_0000);
      wb_rd(REG_STATUS, rd);
      check("ovf_status", rd, 32'd2);
      check("ovf_irq", 32'(irq), 32'd1);
      wb_wr(REG_STATUS, 32'd2);
      wb_rd(REG_STATUS, rd);
      check("w1c_status", rd, 32'd0);
      tick(2);
      check("w1c_irq", 32'(irq), 32'd0);

      // Compare hit, irq timing and period measurement
      wb_wr(REG_POSITION, 32'd0);
      wb_wr(REG_COMPARE, 32'd5);
      for (int i = 0; i < 5; i++) begin
         step_in = 1'b1;
         if (i < 4) begin
            tick(8); step_in = 1'b0; tick(92);
         end else begin
            tick(FL + 3);
            check("cmp_irq_late", 32'(irq), 32'd0);
            tick(1);
            check("cmp_irq", 32'(irq), 32'd1);
            step_in = 1'b0;
            tick(20);
         end
      end
      wb_rd(REG_POSITION, rd);
      check("cmp_pos", rd, 32'd5);
      wb_rd(REG_STATUS, rd);
      check("cmp_status", rd, 32'd1);
      wb_rd(REG_PERIOD, rd);
      check("period", rd, 32'd100);

      // Bus write to POSITION coincident with a count event wins
      wb_wr(REG_STATUS, 32'd7);
      step_in = 1'b1;
      tick(FL + 2);
      wb_wr(REG_POSITION, 32'd42);
      tick(1);
      step_in = 1'b0;
      tick(12);
      wb_rd(REG_POSITION, rd);
      check("wr_collide", rd, 32'd42);
      wb_rd(REG_STATUS, rd);
      check("collide_status", rd, 32'd0);

      // Direction changed one cycle before the step
      dir_in = 1'b0;
      tick(1);
      step_in = 1'b1; tick(8); step_in = 1'b0; tick(12);
      wb_rd(REG_POSITION, rd);
      check("dir_err_pos", rd, 32'd41);
      wb_rd(REG_STATUS, rd);
      check("dir_err_status", rd, 32'd4);
      check("dir_err_no_irq", 32'(irq), 32'd0);

      // Randomized steps and glitches around the signed boundary
      inv = 1'($urandom_range(0, 1));
      st_m = 32'd0;
      pos_m = 32'h7FFF_FFFD;
      wb_wr(REG_STATUS, 32'd7);
      wb_wr(REG_COMPARE, 32'h1234_5678);
      wb_wr(REG_CTRL, {30'd0, inv, 1'b1});
      wb_wr(REG_POSITION, pos_m);
      for (int n = 0; n < 40; n++) begin
         dir = 1'($urandom_range(0, 1));
         dir_in = dir;
         tick(20);
         glitch = ($urandom_range(0, 3) == 0);
         w = glitch ? int'($urandom_range(1, FL - 1)) : int'($urandom_range(FL, FL + 6));
         step_in = 1'b1; tick(w); step_in = 1'b0;
         tick(int'($urandom_range(FL + 4, 20)));
         if (!glitch) begin
            up = dir ^ inv;
            if ((up && pos_m == 32'h7FFF_FFFF) || (!up && pos_m == 32'h8000_0000)) begin
               st_m = st_m | 32'd2;
            end
            pos_m = up ? pos_m + 32'd1 : pos_m - 32'd1;
         end
         wb_rd(REG_POSITION, rd);
         check("rand_pos", rd, pos_m);
      end
      wb_rd(REG_STATUS, rd);
      check("rand_status", rd, st_m);

      // Reset in the middle of a transfer
      wb_wr(REG_CTRL, 32'd5);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = REG_POSITION;
      #2 sys_rst = 1'b1;
      #1;
      check("async_irq", 32'(irq), 32'd0);
      check("async_dat_r", wb_dat_r, 32'd0);
      tick(2);
      check("rst_no_ack", 32'(wb_ack), 32'd0);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      sys_rst = 1'b0;
      tick(2);
      for (int a = 0; a < 5; a++) begin
         wb_rd(13'(a), rd);
         check("rst2_reg", rd, 32'd0);
      end
      wb_wr(13'd7, 32'hFFFF_FFFF);
      wb_rd(13'd7, rd);
      check("unmapped", rd, 32'd0);
      wb_rd(REG_COMPARE, rd);
      check("unmapped_nowrite", rd, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
